// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: read-side consumer of an async FIFO.
// It pops words from the FIFO and packs PACK consecutive words into one wide
// valid/ready beat, with lane0 in the LSBs. A credit-limited skid buffer soaks
// up the FIFO read latency so that backpressure never loses or repeats a word.
// Ports:
//   clk_i          read-domain clock
//   rst_i          synchronous active-high reset
//   fifo_rd_en_o   pop request to the FIFO (the only combinational output)
//   fifo_rd_data_i FIFO read data, valid RD_LATENCY cycles after a pop
//   fifo_empty_i   FIFO empty flag
//   flush_i        pulse: emit a partially packed beat
//   m_valid_o      output beat valid
//   m_ready_i      downstream accept
//   m_data_o       packed beat, lane0 = oldest word
//   m_keep_o       per-lane valid mask

// Catches a skid write while the skid is full; the credit scheme should make this impossible.
module fifo_rd_packer_chk #(
  parameter int SKID_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input logic             clk_i,
  input logic             rst_i,
  input logic             skid_wr_i,
  input logic [CNT_W-1:0] skid_count_i
);
  // Overflow check on every active edge outside reset.
  always @(posedge clk_i) begin
    if (!rst_i && skid_wr_i) begin
      assert (skid_count_i != CNT_W'(SKID_DEPTH))
        else $error("fifo_rd_packer: skid write while full");
    end
  end
endmodule

module fifo_rd_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int PACK       = 2,
  parameter int RD_LATENCY = 1,
  parameter int SKID_DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  output logic                       fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0]      fifo_rd_data_i,
  input  logic                       fifo_empty_i,
  input  logic                       flush_i,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [DATA_WIDTH*PACK-1:0] m_data_o,
  output logic [PACK-1:0]            m_keep_o
);

  localparam int CNT_W  = $clog2(SKID_DEPTH + 1);
  localparam int SUM_W  = CNT_W + 1;
  localparam int PTR_W  = $clog2(SKID_DEPTH);
  localparam int FILL_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int LOAD_W = FILL_W + 1;
  localparam logic [SUM_W-1:0]  DEPTH_SUM = SUM_W'(SKID_DEPTH);
  localparam logic [FILL_W-1:0] LAST_LANE = FILL_W'(PACK - 1);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  logic [RD_LATENCY-1:0]          rd_pipe_r;
  logic [CNT_W-1:0]               inflight_r;
  logic [CNT_W-1:0]               skid_count_r;
  logic [PTR_W-1:0]               skid_wr_ptr_r;
  logic [PTR_W-1:0]               skid_rd_ptr_r;
  logic [DATA_WIDTH-1:0]          skid_mem_r [SKID_DEPTH];
  logic                           rd_en_s;
  logic                           skid_wr_s;
  logic                           skid_rd_s;
  logic                           skid_avail_s;
  logic [DATA_WIDTH-1:0]          skid_head_s;
  state_t                         state_r;
  state_t                         state_nx_s;
  logic [FILL_W-1:0]              fill_r;
  logic [FILL_W-1:0]              fill_nx_s;
  logic [FILL_W-1:0]              ld_idx_s;
  logic [LOAD_W-1:0]              loaded_s;
  logic                           lane_ld_s;
  logic                           lane_clr_s;
  logic [PACK-1:0][DATA_WIDTH-1:0] lanes_r;
  logic [PACK-1:0]                keep_r;
  logic [PACK-1:0]                keep_nx_s;

  // A pop is allowed only if every word already owed to us still has a skid slot.
  assign rd_en_s = !rst_i && !fifo_empty_i &&
                   (({1'b0, skid_count_r} + {1'b0, inflight_r}) < DEPTH_SUM);
  assign fifo_rd_en_o = rd_en_s;

  assign skid_wr_s = rd_pipe_r[RD_LATENCY-1];
  // An empty skid passes the arriving word straight through (write and read in one cycle).
  assign skid_avail_s = (skid_count_r != {CNT_W{1'b0}}) || skid_wr_s;
  assign skid_head_s  = (skid_count_r != {CNT_W{1'b0}}) ? skid_mem_r[skid_rd_ptr_r]
                                                        : fifo_rd_data_i;

  assign m_valid_o = (state_r == ST_HOLD);
  assign m_data_o  = lanes_r;
  assign m_keep_o  = keep_r;

  // Read-latency valid pipe and the in-flight pop counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_pipe_r  <= {RD_LATENCY{1'b0}};
      inflight_r <= {CNT_W{1'b0}};
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        rd_pipe_r[i] <= rd_pipe_r[i-1];
      end
      rd_pipe_r[0] <= rd_en_s;
      inflight_r   <= inflight_r + CNT_W'(rd_en_s) - CNT_W'(skid_wr_s);
    end
  end

  // Skid buffer pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      skid_wr_ptr_r <= {PTR_W{1'b0}};
      skid_rd_ptr_r <= {PTR_W{1'b0}};
      skid_count_r  <= {CNT_W{1'b0}};
    end else begin
      if (skid_wr_s) begin
        skid_wr_ptr_r <= skid_wr_ptr_r + PTR_W'(1);
      end
      if (skid_rd_s) begin
        skid_rd_ptr_r <= skid_rd_ptr_r + PTR_W'(1);
      end
      skid_count_r <= skid_count_r + CNT_W'(skid_wr_s) - CNT_W'(skid_rd_s);
    end
  end

  // Skid buffer storage.
  always_ff @(posedge clk_i) begin
    if (!rst_i && skid_wr_s) begin
      skid_mem_r[skid_wr_ptr_r] <= fifo_rd_data_i;
    end
  end

  // Packer next-state and lane control.
  always_comb begin
    state_nx_s = state_r;
    fill_nx_s  = fill_r;
    keep_nx_s  = keep_r;
    ld_idx_s   = fill_r;
    lane_ld_s  = 1'b0;
    lane_clr_s = 1'b0;
    skid_rd_s  = 1'b0;
    // Lanes holding data once this cycle's load (if any) lands.
    loaded_s   = LOAD_W'(fill_r) + LOAD_W'(skid_avail_s);
    case (state_r)
      ST_FILL: begin
        if (skid_avail_s) begin
          skid_rd_s = 1'b1;
          lane_ld_s = 1'b1;
          fill_nx_s = fill_r + FILL_W'(1);
        end else begin
          fill_nx_s = fill_r;
        end
        if (skid_avail_s && (fill_r == LAST_LANE)) begin
          state_nx_s = ST_HOLD;
          fill_nx_s  = {FILL_W{1'b0}};
          keep_nx_s  = {PACK{1'b1}};
        end else if (flush_i && (loaded_s != {LOAD_W{1'b0}})) begin
          state_nx_s = ST_HOLD;
          fill_nx_s  = {FILL_W{1'b0}};
          for (int i = 0; i < PACK; i++) begin
            keep_nx_s[i] = (LOAD_W'(i) < loaded_s);
          end
        end else begin
          state_nx_s = ST_FILL;
        end
      end
      ST_HOLD: begin
        if (m_ready_i) begin
          state_nx_s = ST_FILL;
          lane_clr_s = 1'b1;
          keep_nx_s  = {PACK{1'b0}};
          ld_idx_s   = {FILL_W{1'b0}};
          if (skid_avail_s) begin
            skid_rd_s = 1'b1;
            lane_ld_s = 1'b1;
            fill_nx_s = FILL_W'(1);
          end else begin
            fill_nx_s = {FILL_W{1'b0}};
          end
        end else begin
          state_nx_s = ST_HOLD;
        end
      end
      default: begin
        state_nx_s = ST_FILL;
        fill_nx_s  = {FILL_W{1'b0}};
        keep_nx_s  = {PACK{1'b0}};
      end
    endcase
  end

  // Packer state, fill index, keep mask and lane registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_FILL;
      fill_r  <= {FILL_W{1'b0}};
      keep_r  <= {PACK{1'b0}};
      lanes_r <= {(DATA_WIDTH*PACK){1'b0}};
    end else begin
      state_r <= state_nx_s;
      fill_r  <= fill_nx_s;
      keep_r  <= keep_nx_s;
      if (lane_clr_s) begin
        lanes_r <= {(DATA_WIDTH*PACK){1'b0}};
      end
      if (lane_ld_s) begin
        lanes_r[ld_idx_s] <= skid_head_s;
      end
    end
  end

  fifo_rd_packer_chk #(
    .SKID_DEPTH(SKID_DEPTH),
    .CNT_W     (CNT_W)
  ) u_chk (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .skid_wr_i   (skid_wr_s),
    .skid_count_i(skid_count_r)
  );

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Testbench for fifo_rd_packer: a queue-based FIFO model feeds the DUT and a
// word-level scoreboard checks every accepted beat against push order.
module tb_fifo_rd_packer;
  localparam int DW = 16;
  localparam int PK = 2;

  logic              clk_i;
  logic              rst_i;
  logic              fifo_rd_en_o;
  logic [DW-1:0]     fifo_rd_data_i;
  logic              fifo_empty_i;
  logic              flush_i;
  logic              m_valid_o;
  logic              m_ready_i;
  logic [DW*PK-1:0]  m_data_o;
  logic [PK-1:0]     m_keep_o;

  fifo_rd_packer #(
    .DATA_WIDTH(DW), .PACK(PK), .RD_LATENCY(1), .SKID_DEPTH(4)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .fifo_rd_en_o  (fifo_rd_en_o),
    .fifo_rd_data_i(fifo_rd_data_i),
    .fifo_empty_i  (fifo_empty_i),
    .flush_i       (flush_i),
    .m_valid_o     (m_valid_o),
    .m_ready_i     (m_ready_i),
    .m_data_o      (m_data_o),
    .m_keep_o      (m_keep_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] fifoq [$];
  logic [DW-1:0] expq  [$];
  bit            gate_empty = 1'b0;
  int            beats = 0;
  int            pops  = 0;
  logic [DW*PK-1:0] last_data;
  logic [PK-1:0]    last_keep;
  bit            smp_pop, smp_valid;
  bit            prev_stall = 1'b0;
  logic [DW*PK-1:0] prev_data;
  logic [PK-1:0]    prev_keep;

  // One clock cycle: entered and left just after a falling edge.
  task automatic step();
    logic [DW-1:0] lane;
    logic [DW-1:0] exp_w;
    fifo_empty_i = (fifoq.size() == 0) || gate_empty;
    #1;
    smp_pop   = fifo_rd_en_o;
    smp_valid = m_valid_o;
    checks++;
    if (smp_pop && fifo_empty_i) begin
      failures++;
      $display("FAIL rd_en_while_empty: rd_en=%0b empty=%0b", smp_pop, fifo_empty_i);
    end
    if (prev_stall && !rst_i) begin
      checks++;
      if (m_valid_o !== 1'b1 || m_data_o !== prev_data || m_keep_o !== prev_keep) begin
        failures++;
        $display("FAIL hold_stable: valid=%0b data=%h keep=%b, expected valid=1 data=%h keep=%b",
                 m_valid_o, m_data_o, m_keep_o, prev_data, prev_keep);
      end
    end
    if (m_valid_o && m_ready_i && !rst_i) begin
      beats++;
      last_data = m_data_o;
      last_keep = m_keep_o;
      checks++;
      if (m_keep_o == 2'b00 || m_keep_o == 2'b10) begin
        failures++;
        $display("FAIL keep_shape: keep=%b, expected 01 or 11", m_keep_o);
      end
      for (int l = 0; l < PK; l++) begin
        lane = m_data_o[l*DW +: DW];
        checks++;
        if (m_keep_o[l]) begin
          if (expq.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_extra: lane%0d=%h, expected no word", l, lane);
          end else begin
            exp_w = expq.pop_front();
            if (lane !== exp_w) begin
              failures++;
              $display("FAIL scoreboard_word: lane%0d=%h, expected %h", l, lane, exp_w);
            end
          end
        end else if (lane !== 16'h0000) begin
          failures++;
          $display("FAIL unloaded_lane: lane%0d=%h, expected 0000", l, lane);
        end
      end
    end
    prev_stall = m_valid_o && !m_ready_i && !rst_i;
    prev_data  = m_data_o;
    prev_keep  = m_keep_o;
    if (smp_pop) pops++;
    @(posedge clk_i);
    #1;
    if (smp_pop && fifoq.size() > 0) fifo_rd_data_i = fifoq.pop_front();
    else fifo_rd_data_i = 16'($urandom);
    @(negedge clk_i);
  endtask

  task automatic push(input logic [DW-1:0] w, input bit expected);
    fifoq.push_back(w);
    if (expected) expq.push_back(w);
  endtask

  task automatic wait_beats(input int target, input int budget, input string name);
    int n = 0;
    while (beats < target && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (beats != target) begin
      failures++;
      $display("FAIL %s_timeout: beats=%0d, expected %0d", name, beats, target);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    fifo_empty_i = 1'b0;
    flush_i = 1'b0;
    m_ready_i = 1'b0;
    fifo_rd_data_i = 16'h0000;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i);
      #1;
      checks++;
      if (fifo_rd_en_o !== 1'b0 || m_valid_o !== 1'b0 || m_keep_o !== 2'b00 || m_data_o !== 32'h0) begin
        failures++;
        $display("FAIL reset_outputs: rd_en=%0b valid=%0b keep=%b data=%h, expected all 0",
                 fifo_rd_en_o, m_valid_o, m_keep_o, m_data_o);
      end
    end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_basic();
    int first_valid = -1;
    int first_pop = -1;
    logic [DW*PK-1:0] got [2];
    push(16'd10, 1'b1); push(16'd20, 1'b1); push(16'd30, 1'b1); push(16'd40, 1'b1);
    m_ready_i = 1'b1;
    beats = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (smp_pop && first_pop < 0) first_pop = k;
      if (smp_valid && first_valid < 0) first_valid = k;
      if (m_ready_i && smp_valid && beats <= 2) got[beats-1] = last_data;
    end
    checks++;
    if (first_pop != 0 || first_valid != 3) begin
      failures++;
      $display("FAIL first_latency: pop@%0d valid@%0d, expected pop@0 valid@3", first_pop, first_valid);
    end
    checks++;
    if (beats != 2) begin
      failures++;
      $display("FAIL basic_beats: beats=%0d, expected 2", beats);
    end else begin
      checks++;
      if (got[0] !== 32'h0014000A || got[1] !== 32'h0028001E || last_keep !== 2'b11) begin
        failures++;
        $display("FAIL basic_data: %h %h keep=%b, expected 0014000a 0028001e keep=11",
                 got[0], got[1], last_keep);
      end
    end
    checks++;
    if (fifo_rd_en_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle_rd_en: rd_en=%0b, expected 0", fifo_rd_en_o);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 10; i++) push(16'($urandom), 1'b1);
    m_ready_i = 1'b0;
    pops = 0;
    beats = 0;
    repeat (20) step();
    checks++;
    if (pops != 6) begin
      failures++;
      $display("FAIL bp_pops: pops=%0d, expected 6", pops);
    end
    checks++;
    if (m_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_valid: valid=%0b, expected 1", m_valid_o);
    end
    m_ready_i = 1'b1;
    wait_beats(5, 40, "bp");
    checks++;
    if (expq.size() != 0 || last_keep !== 2'b11) begin
      failures++;
      $display("FAIL bp_drain: left=%0d keep=%b, expected 0 left keep=11", expq.size(), last_keep);
    end
  endtask

  task automatic test_flush();
    m_ready_i = 1'b1;
    beats = 0;
    push(16'h0005, 1'b1);
    repeat (4) step();
    checks++;
    if (beats != 0) begin
      failures++;
      $display("FAIL flush_early: beats=%0d, expected 0", beats);
    end
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    wait_beats(1, 10, "flush");
    checks++;
    if (last_data !== 32'h00000005 || last_keep !== 2'b01) begin
      failures++;
      $display("FAIL flush_beat: data=%h keep=%b, expected 00000005 keep=01", last_data, last_keep);
    end
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    repeat (5) step();
    checks++;
    if (beats != 1) begin
      failures++;
      $display("FAIL flush_empty_ignored: beats=%0d, expected 1", beats);
    end
  endtask

  task automatic test_random();
    int n = 0;
    beats = 0;
    for (int i = 0; i < 64; i++) push(16'($urandom), 1'b1);
    while (beats < 32 && n < 2000) begin
      gate_empty = ((n / 3) % 2) == 1;
      m_ready_i  = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    gate_empty = 1'b0;
    m_ready_i  = 1'b1;
    checks++;
    if (beats != 32 || expq.size() != 0) begin
      failures++;
      $display("FAIL random_drain: beats=%0d left=%0d, expected 32 beats 0 left", beats, expq.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w;
    m_ready_i = 1'b1;
    beats = 0;
    push(16'hAAAA, 1'b0);
    step();
    step();
    push(16'hBBBB, 1'b0);
    step();
    checks++;
    if (!smp_pop) begin
      failures++;
      $display("FAIL mid_pop_in_flight: rd_en=%0b, expected 1", smp_pop);
    end
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    repeat (6) step();
    checks++;
    if (beats != 0) begin
      failures++;
      $display("FAIL mid_no_beat: beats=%0d, expected 0", beats);
    end
    w = 16'($urandom);
    push(w, 1'b1);
    repeat (4) step();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    wait_beats(1, 10, "mid");
    checks++;
    if (last_data !== {16'h0000, w} || last_keep !== 2'b01) begin
      failures++;
      $display("FAIL mid_lane0: data=%h keep=%b, expected %h keep=01", last_data, last_keep, {16'h0000, w});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
